// File: rtl/qbus_master.sv
// qbus_master: two-port bus-cycle sequencer driving DATI/DATO/DATOB cycles on the
// 1801VM1-style multiplexed bus. Define BUS_TIMEOUT_EN to add the reply timeout and err.
module qbus_master #(
    parameter int SETUP   = 2,
    parameter int HOLD    = 1,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [1:0]  byte_en,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic [1:0]  ack,
    output logic        err,
    output logic [15:0] rdata,
    inout  wire  [15:0] ad_n,
    output logic [1:0]  sel_n,
    output logic        sync_n,
    output logic        din_n,
    output logic        dout_n,
    output logic        wtbt_n,
    input  logic        rply_n
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_SYNC, S_DATA, S_WAITR, S_RELS, S_END
    } state_t;

    typedef struct packed {
        logic        we;
        logic        byte_en;
        logic [15:0] addr;
        logic [15:0] wdata;
    } qreq_t;

    state_t      state, state_nx;
    qreq_t [1:0] port_req;
    qreq_t       cur;
    logic        gnt, gnt_nx, rr;
    logic [7:0]  pcnt;
    logic [1:0]  rply_sync;
    logic        rply_raw, rply_s;
    logic        tmo_end;
    logic        ad_oe;
    logic [15:0] ad_out;
    logic [15:0] wr_word;

    if (TIMEOUT < 1) begin : g_bad_timeout_min
        $error("qbus_master: TIMEOUT must be at least 1");
    end

    assign port_req[0] = '{we: we[0], byte_en: byte_en[0], addr: addr0, wdata: wdata0};
    assign port_req[1] = '{we: we[1], byte_en: byte_en[1], addr: addr1, wdata: wdata1};

    assign sel_n   = 2'b11;
    assign wr_word = cur.byte_en ? {2{cur.wdata[7:0]}} : cur.wdata;
    assign ad_n    = ad_oe ? ad_out : 16'hzzzz;

    // A floating or unknown reply line reads as "no reply".
    assign rply_raw = (rply_n === 1'b0) ? 1'b0 : 1'b1;
    assign rply_s   = rply_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rply_sync <= 2'b11;
        else     rply_sync <= {rply_sync[0], rply_raw};
    end

    // rr names the port that wins when both request at once.
    assign gnt_nx = (req == 2'b11) ? rr : req[1];

`ifdef BUS_TIMEOUT_EN
    if (TIMEOUT > 255) begin : g_bad_timeout_max
        $error("qbus_master: TIMEOUT must fit the 8-bit timeout counter");
    end

    logic [7:0] tcnt;
    logic       timed_out;
    logic       err_q;

    // tcnt is 0 in the DATA cycle, so TIMEOUT counts cycles of strobe assertion.
    assign timed_out = (state == S_WAITR || state == S_RELS) && (tcnt >= 8'(TIMEOUT - 1));
    assign tmo_end   = timed_out && ((state == S_WAITR && rply_s) || (state == S_RELS && !rply_s));
    assign err       = (state == S_END) && err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt  <= 8'd0;
            err_q <= 1'b0;
        end else begin
            tcnt  <= (state == S_DATA || state == S_WAITR || state == S_RELS) ? tcnt + 8'd1 : 8'd0;
            err_q <= tmo_end;
        end
    end
`else
    assign tmo_end = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (|req) state_nx = S_ADDR;
            S_ADDR:  if (pcnt == 8'(SETUP - 1)) state_nx = S_SYNC;
            S_SYNC:  if (pcnt == 8'(HOLD - 1)) state_nx = S_DATA;
            S_DATA:  state_nx = S_WAITR;
            S_WAITR: begin
                if (!rply_s)      state_nx = S_RELS;
                else if (tmo_end) state_nx = S_END;
            end
            S_RELS:  if (rply_s || tmo_end) state_nx = S_END;
            S_END:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Strobes decode straight from state so an async reset releases them at once.
    always_comb begin
        sync_n = 1'b1;
        din_n  = 1'b1;
        dout_n = 1'b1;
        wtbt_n = 1'b1;
        ad_oe  = 1'b0;
        ad_out = ~cur.addr;
        ack    = 2'b00;
        unique case (state)
            S_ADDR: begin
                ad_oe  = 1'b1;
                wtbt_n = ~cur.we;
            end
            S_SYNC: begin
                sync_n = 1'b0;
                ad_oe  = 1'b1;
                wtbt_n = ~cur.we;
            end
            S_DATA, S_WAITR: begin
                sync_n = 1'b0;
                if (cur.we) begin
                    ad_oe  = 1'b1;
                    ad_out = ~wr_word;
                    dout_n = 1'b0;
                    wtbt_n = ~cur.byte_en;
                end else begin
                    din_n  = 1'b0;
                end
            end
            S_RELS: begin
                sync_n = 1'b0;
                if (cur.we) begin
                    ad_oe  = 1'b1;
                    ad_out = ~wr_word;
                    wtbt_n = ~cur.byte_en;
                end
            end
            S_END:   ack = gnt ? 2'b10 : 2'b01;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            pcnt  <= 8'd0;
            gnt   <= 1'b0;
            rr    <= 1'b0;
            cur   <= '0;
            rdata <= 16'h0000;
        end else begin
            state <= state_nx;
            pcnt  <= (state_nx != state) ? 8'd0 : pcnt + 8'd1;
            if (state == S_IDLE && |req) begin
                gnt <= gnt_nx;
                rr  <= ~gnt_nx;
                cur <= port_req[gnt_nx];
            end
            if (state == S_WAITR && !rply_s && !cur.we)
                rdata <= ~ad_n;
        end
    end
endmodule
